// File: rtl/riscv_alu_pkg.sv
// Shared ALU definitions: op code encoding and pipeline latency.
// Imported by the ALU and by every block that feeds it.
package riscv_alu_pkg;

  localparam int ALU_LAT = 3;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_XOR  = 4'd3,
    ALU_SRL  = 4'd4,
    ALU_SRA  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_AND  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

endpackage

// File: rtl/riscv_rr_arb2.sv
// Two-way round-robin arbiter with last-grant state, reusable for any
// shared single-issue unit. Grants are combinational, at most one per cycle.
module riscv_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio;  // port that wins the next conflict

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    gnt = '0;
    if (en) begin
      if (req == 2'b11) gnt[prio] = 1'b1;
      else              gnt       = req;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    prio <= 1'b0;
    else if (|gnt) prio <= gnt[0];
  end

endmodule

// File: rtl/riscv_alu_arbiter.sv
// Shares one fixed-latency pipelined ALU between two issue ports. A shadow
// pipe tracks owner and tag per ALU stage so results route back in order.
module riscv_alu_arbiter #(
  parameter int TAG_W   = 5,
  parameter int ALU_LAT = riscv_alu_pkg::ALU_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [3:0]       req0_op,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [3:0]       req1_op,
  input  logic [TAG_W-1:0] req1_tag,
  input  logic             flush,
  output logic [31:0]      alu_operand_a,
  output logic [31:0]      alu_operand_b,
  output logic [3:0]       alu_op,
  output logic             alu_valid_in,
  input  logic [31:0]      alu_result,
  input  logic             alu_valid_out,
  output logic             resp0_valid,
  output logic [31:0]      resp0_result,
  output logic [TAG_W-1:0] resp0_tag,
  output logic             resp1_valid,
  output logic [31:0]      resp1_result,
  output logic [TAG_W-1:0] resp1_tag,
  output logic [2:0]       inflight,
  output logic             err
);

  localparam int TAIL = ALU_LAT - 1;

  logic [1:0]         gnt;
  logic               issue;
  logic               win;
  logic               resp_fire;
  logic [ALU_LAT-1:0] sh_issued;
  logic [ALU_LAT-1:0] sh_live;
  logic [ALU_LAT-1:0] sh_port;
  logic [TAG_W-1:0]   sh_tag [ALU_LAT];

  // Reset also masks grants so ready/valid drop the moment rst_n falls.
  riscv_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (rst_n & ~flush),
    .req   ({req1_valid, req0_valid}),
    .gnt   (gnt)
  );

  assign req0_ready    = gnt[0];
  assign req1_ready    = gnt[1];
  assign issue         = |gnt;
  assign win           = gnt[1];
  assign alu_valid_in  = issue;
  assign alu_operand_a = win ? req1_a  : req0_a;
  assign alu_operand_b = win ? req1_b  : req0_b;
  assign alu_op        = win ? req1_op : req0_op;

  // Flush kills ownership but keeps 'issued', so the ALU's late results
  // are still expected (no err) and simply discarded.
  assign resp_fire = alu_valid_out & sh_live[TAIL] & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_issued   <= '0;
      sh_live     <= '0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      sh_issued   <= {sh_issued[ALU_LAT-2:0], issue};
      sh_live     <= flush ? '0 : {sh_live[ALU_LAT-2:0], issue};
      resp0_valid <= resp_fire & ~sh_port[TAIL];
      resp1_valid <= resp_fire &  sh_port[TAIL];
      err         <= err | (alu_valid_out != sh_issued[TAIL]);
    end
  end

  // NOTE: data-only registers carry no reset; their valid bits gate every use.
  always_ff @(posedge clk) begin
    sh_port   <= {sh_port[ALU_LAT-2:0], win};
    sh_tag[0] <= win ? req1_tag : req0_tag;
    for (int i = 1; i < ALU_LAT; i++) sh_tag[i] <= sh_tag[i-1];
    if (resp_fire && !sh_port[TAIL]) begin
      resp0_result <= alu_result;
      resp0_tag    <= sh_tag[TAIL];
    end
    if (resp_fire && sh_port[TAIL]) begin
      resp1_result <= alu_result;
      resp1_tag    <= sh_tag[TAIL];
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < ALU_LAT; i++) inflight = inflight + 3'(sh_live[i]);
    inflight = inflight + 3'(resp0_valid) + 3'(resp1_valid);
  end

endmodule

// File: tb/tb_riscv_alu_arbiter.sv
// Bench for riscv_alu_arbiter: behavioural 3-cycle ALU, directed vector table,
// hand-written flush/error/reset sequences and a randomized scoreboard phase.
module tb_riscv_alu_arbiter;
  import riscv_alu_pkg::*;

  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             req0_valid, req1_valid, req0_ready, req1_ready, flush;
  logic [31:0]      req0_a, req0_b, req1_a, req1_b;
  logic [3:0]       req0_op, req1_op;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic [31:0]      alu_operand_a, alu_operand_b, alu_result;
  logic [3:0]       alu_op;
  logic             alu_valid_in, alu_valid_out;
  logic             resp0_valid, resp1_valid;
  logic [31:0]      resp0_result, resp1_result;
  logic [TAG_W-1:0] resp0_tag, resp1_tag;
  logic [2:0]       inflight;
  logic             err;
  logic             force_vo = 1'b0;

  int checks = 0;
  int failures = 0;

  riscv_alu_arbiter #(.TAG_W(TAG_W), .ALU_LAT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_tag(req1_tag),
    .flush(flush),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b), .alu_op(alu_op),
    .alu_valid_in(alu_valid_in), .alu_result(alu_result), .alu_valid_out(alu_valid_out),
    .resp0_valid(resp0_valid), .resp0_result(resp0_result), .resp0_tag(resp0_tag),
    .resp1_valid(resp1_valid), .resp1_result(resp1_result), .resp1_tag(resp1_tag),
    .inflight(inflight), .err(err)
  );

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'b0, a < b};
      default:  return 32'b0;
    endcase
  endfunction

  // Behavioural ALU: three stages, result visible ALU_LAT cycles after valid_in.
  logic [31:0] alu_res_p [3];
  logic [2:0]  alu_v_p;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) alu_v_p <= '0;
    else begin
      alu_v_p      <= {alu_v_p[1:0], alu_valid_in};
      alu_res_p[0] <= alu_fn(alu_op, alu_operand_a, alu_operand_b);
      alu_res_p[1] <= alu_res_p[0];
      alu_res_p[2] <= alu_res_p[1];
    end
  end
  assign alu_valid_out = alu_v_p[2] | force_vo;
  assign alu_result    = alu_res_p[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0; req0_tag = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0; req1_tag = 0;
    flush = 0; force_vo = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          rst;
    logic        v0; logic [3:0] op0; logic [31:0] a0, b0; logic [4:0] t0;
    logic        v1; logic [3:0] op1; logic [31:0] a1, b1; logic [4:0] t1;
    logic        fl;
    logic        rdy0, rdy1;
    logic        rv0; logic [31:0] res0; logic [4:0] tg0;
    logic        rv1; logic [31:0] res1; logic [4:0] tg1;
    logic [2:0]  infl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst,
                     input logic v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0, input logic [4:0] t0,
                     input logic v1, input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1, input logic [4:0] t1,
                     input logic fl, input logic rdy0, input logic rdy1,
                     input logic rv0, input logic [31:0] res0, input logic [4:0] tg0,
                     input logic rv1, input logic [31:0] res1, input logic [4:0] tg1,
                     input logic [2:0] infl);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.op0 = op0; v.a0 = a0; v.b0 = b0; v.t0 = t0;
    v.v1 = v1; v.op1 = op1; v.a1 = a1; v.b1 = b1; v.t1 = t1; v.fl = fl;
    v.rdy0 = rdy0; v.rdy1 = rdy1; v.rv0 = rv0; v.res0 = res0; v.tg0 = tg0;
    v.rv1 = rv1; v.res1 = res1; v.tg1 = tg1; v.infl = infl;
    vecs.push_back(v);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    if (v.rst) do_reset();
    req0_valid = v.v0; req0_op = v.op0; req0_a = v.a0; req0_b = v.b0; req0_tag = v.t0;
    req1_valid = v.v1; req1_op = v.op1; req1_a = v.a1; req1_b = v.b1; req1_tag = v.t1;
    flush = v.fl;
    @(negedge clk);
    check($sformatf("vec%0d req0_ready", idx), req0_ready, v.rdy0);
    check($sformatf("vec%0d req1_ready", idx), req1_ready, v.rdy1);
    check($sformatf("vec%0d alu_valid_in", idx), alu_valid_in, v.rdy0 | v.rdy1);
    check($sformatf("vec%0d resp0_valid", idx), resp0_valid, v.rv0);
    check($sformatf("vec%0d resp1_valid", idx), resp1_valid, v.rv1);
    if (v.rv0) begin
      check($sformatf("vec%0d resp0_result", idx), resp0_result, v.res0);
      check($sformatf("vec%0d resp0_tag", idx), resp0_tag, v.tg0);
    end
    if (v.rv1) begin
      check($sformatf("vec%0d resp1_result", idx), resp1_result, v.res1);
      check($sformatf("vec%0d resp1_tag", idx), resp1_tag, v.tg1);
    end
    check($sformatf("vec%0d inflight", idx), inflight, v.infl);
    check($sformatf("vec%0d err", idx), err, 1'b0);
    next_cycle();
  endtask

  // Scoreboard entry: response due in cycle 'due' on port 'port'.
  typedef struct { int due; bit port; logic [31:0] res; logic [4:0] tag; } pend_t;
  pend_t pq[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive_idle();

    // Single op
    add(1, 1, ALU_ADD, 5, 7, 3,  0, 0, 0, 0, 0,  0, 1, 0,  0, 0, 0,  0, 0, 0,  0);
    for (int c = 1; c <= 3; c++)
      add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,  1);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  1, 12, 3,  0, 0, 0,  1);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,  0);

    // Conflict: grants alternate starting with port 0
    for (int c = 0; c < 6; c++)
      add(c == 0, 1, ALU_SUB, 10, 3, 1,  1, ALU_XOR, 32'hF0, 32'h0F, 2,  0,
          c % 2 == 0, c % 2 == 1,
          c == 4, 7, 1,  c == 5, 32'hFF, 2,  3'(c < 4 ? c : 4));
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  1, 7, 1,  0, 0, 0,  4);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 32'hFF, 2,  3);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  1, 7, 1,  0, 0, 0,  2);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 32'hFF, 2,  1);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,  0);

    // Back-to-back SLT on port 1
    add(1, 0, 0, 0, 0, 0,  1, ALU_SLT, 32'hFFFF_FFFF, 0, 4,  0, 0, 1,  0, 0, 0,  0, 0, 0,  0);
    add(0, 0, 0, 0, 0, 0,  1, ALU_SLT, 2, 1, 5,  0, 0, 1,  0, 0, 0,  0, 0, 0,  1);
    add(0, 0, 0, 0, 0, 0,  1, ALU_SLT, 32'hFFFF_FFFB, 32'hFFFF_FFFD, 6,  0, 0, 1,  0, 0, 0,  0, 0, 0,  2);
    add(0, 0, 0, 0, 0, 0,  1, ALU_SLT, 7, 7, 7,  0, 0, 1,  0, 0, 0,  0, 0, 0,  3);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 1, 4,  4);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 5,  3);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 1, 6,  2);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 7,  1);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,  0);

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);

    // Flush: issues in cycles 0 and 1, flush in cycle 2 with a valid request
    do_reset();
    req0_valid = 1; req0_op = ALU_ADD; req0_a = 1; req0_b = 1; req0_tag = 8;
    @(negedge clk); check("flush c0 req0_ready", req0_ready, 1'b1);
    next_cycle();
    req0_valid = 0; req1_valid = 1; req1_op = ALU_ADD; req1_a = 2; req1_b = 2; req1_tag = 9;
    @(negedge clk); check("flush c1 req1_ready", req1_ready, 1'b1);
    next_cycle();
    req0_valid = 1; req1_valid = 0; flush = 1;
    @(negedge clk);
    check("flush c2 req0_ready", req0_ready, 1'b0);
    check("flush c2 req1_ready", req1_ready, 1'b0);
    check("flush c2 alu_valid_in", alu_valid_in, 1'b0);
    next_cycle();
    drive_idle();
    for (int c = 3; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("flush c%0d inflight", c), inflight, 3'd0);
      check($sformatf("flush c%0d resp0_valid", c), resp0_valid, 1'b0);
      check($sformatf("flush c%0d resp1_valid", c), resp1_valid, 1'b0);
      check($sformatf("flush c%0d err", c), err, 1'b0);
      next_cycle();
    end

    // Spurious ALU result in cycle 3 sets sticky err
    do_reset();
    for (int c = 0; c <= 3; c++) begin
      force_vo = (c == 3);
      @(negedge clk); check($sformatf("errseq c%0d err", c), err, 1'b0);
      next_cycle();
    end
    force_vo = 0;
    for (int c = 4; c <= 8; c++) begin
      @(negedge clk);
      check($sformatf("errseq c%0d err", c), err, 1'b1);
      check($sformatf("errseq c%0d resp0_valid", c), resp0_valid, 1'b0);
      next_cycle();
    end
    rst_n = 0; #1;
    check("errseq reset err", err, 1'b0);

    // Async reset with two ops in flight
    do_reset();
    req0_valid = 1; req0_op = ALU_ADD; req0_a = 3; req0_b = 4; req0_tag = 10;
    next_cycle();
    req0_valid = 0; req1_valid = 1; req1_op = ALU_OR; req1_a = 1; req1_b = 2; req1_tag = 11;
    next_cycle();
    req0_valid = 1;
    #2 rst_n = 0; #1;
    check("rst req0_ready", req0_ready, 1'b0);
    check("rst req1_ready", req1_ready, 1'b0);
    check("rst alu_valid_in", alu_valid_in, 1'b0);
    check("rst resp0_valid", resp0_valid, 1'b0);
    check("rst resp1_valid", resp1_valid, 1'b0);
    check("rst inflight", inflight, 3'd0);
    drive_idle();
    @(negedge clk) rst_n = 1;
    next_cycle();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("postrst c%0d resp0_valid", c), resp0_valid, 1'b0);
      check($sformatf("postrst c%0d resp1_valid", c), resp1_valid, 1'b0);
      check($sformatf("postrst c%0d err", c), err, 1'b0);
      next_cycle();
    end
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    check("postrst conflict req0_ready", req0_ready, 1'b1);
    check("postrst conflict req1_ready", req1_ready, 1'b0);
    next_cycle();

    // Randomized traffic against a scoreboard of due responses
    do_reset();
    pq.delete();
    begin
      int prio = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
        int g;
        int n_live;
        bit ev0, ev1;
        pend_t e0, e1;
        req0_valid = ($urandom_range(0, 99) < 55);
        req1_valid = ($urandom_range(0, 99) < 55);
        req0_a = $urandom; req0_b = $urandom_range(0, 40); req0_op = 4'($urandom_range(0, 9)); req0_tag = 5'($urandom);
        req1_a = $urandom; req1_b = $urandom;              req1_op = 4'($urandom_range(0, 9)); req1_tag = 5'($urandom);
        flush = ($urandom_range(0, 15) == 0);
        @(negedge clk);
        if (flush)                       g = -1;
        else if (req0_valid && req1_valid) g = prio;
        else if (req0_valid)             g = 0;
        else if (req1_valid)             g = 1;
        else                             g = -1;
        ev0 = 0; ev1 = 0; n_live = 0;
        foreach (pq[i]) begin
          if (pq[i].due == cyc && !pq[i].port) begin ev0 = 1; e0 = pq[i]; end
          if (pq[i].due == cyc &&  pq[i].port) begin ev1 = 1; e1 = pq[i]; end
          if (pq[i].due >= cyc && pq[i].due <= cyc + 3) n_live++;
        end
        check("rand req0_ready", req0_ready, g == 0);
        check("rand req1_ready", req1_ready, g == 1);
        check("rand resp0_valid", resp0_valid, ev0);
        check("rand resp1_valid", resp1_valid, ev1);
        if (ev0) begin
          check("rand resp0_result", resp0_result, e0.res);
          check("rand resp0_tag", resp0_tag, e0.tag);
        end
        if (ev1) begin
          check("rand resp1_result", resp1_result, e1.res);
          check("rand resp1_tag", resp1_tag, e1.tag);
        end
        check("rand inflight", inflight, 32'(n_live));
        check("rand err", err, 1'b0);
        if (g == 0) begin
          pq.push_back('{due: cyc + 4, port: 1'b0, res: alu_fn(req0_op, req0_a, req0_b), tag: req0_tag});
          prio = 1;
        end else if (g == 1) begin
          pq.push_back('{due: cyc + 4, port: 1'b1, res: alu_fn(req1_op, req1_a, req1_b), tag: req1_tag});
          prio = 0;
        end
        for (int i = pq.size() - 1; i >= 0; i--)
          if (pq[i].due <= cyc || (flush && pq[i].due > cyc)) pq.delete(i);
        next_cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
